// File: rtl/spi_slave_responder.sv
// SPI target responder: clk-domain oversampler, all CPOL/CPHA modes, MSB/LSB-first; SPI_SLAVE_ECHO_EN echoes last rx char on tx underrun.
// rx_valid <= SYNC_STAGES+2 clk after the raw final sample edge, no rx backpressure (unread char overwritten); tx via valid/ready holding register.
module spi_slave_responder #(
    parameter int CHAR_LENGTH = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_cpol,
    input  logic                   cfg_cpha,
    input  logic                   cfg_msb_first,
    input  logic                   sclk_i,
    input  logic                   cs_n_i,
    input  logic                   mosi_i,
    output logic                   miso_o,
    output logic                   miso_oe,
    input  logic [CHAR_LENGTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [CHAR_LENGTH-1:0] rx_data,
    output logic                   rx_valid,
    output logic                   tx_underrun,
    output logic                   busy
);
    localparam int CW = (CHAR_LENGTH > 1) ? $clog2(CHAR_LENGTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAR_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;
    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, fill_q;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_prev_q, armed_q;

    logic                   cpol_q, cpol_d, cpha_q, cpha_d, msb_q, msb_d;
    logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
    logic [CHAR_LENGTH-1:0] rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
    logic [CHAR_LENGTH-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
    logic                   hold_full_q, hold_full_d;
    logic                   miso_q, miso_d, rx_valid_q, rx_valid_d;
    logic                   underrun_q, underrun_d, upend_q, upend_d;

    logic                   sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic                   in_xfer, sample_edge, shift_edge, last_sample;
    logic                   do_load;
    logic [CHAR_LENGTH-1:0] rx_word, fill_val, load_val;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // fill_q marks when the sync chains hold post-reset samples; armed_q then
    // requires a genuine deselect before a frame may start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            armed_q     <= armed_q | (fill_q[SYNC_STAGES-1] & cs_s);
        end
    end

    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
    assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
    assign in_xfer     = (state_q == XFER);
    assign sample_edge = in_xfer & (cpha_q ? trail_edge : lead_edge);
    assign shift_edge  = in_xfer & (cpha_q ? lead_edge : trail_edge);
    assign last_sample = sample_edge & (bit_cnt_q == LAST_BIT);
    assign rx_word     = msb_q ? {rx_sh_q[CHAR_LENGTH-2:0], mosi_s}
                               : {mosi_s, rx_sh_q[CHAR_LENGTH-1:1]};

`ifdef SPI_SLAVE_ECHO_EN
    // At a char boundary rx_data_q is being overwritten, so echo the char just completed.
    assign fill_val = (state_q == LOAD) ? rx_data_q : rx_word;
`else
    assign fill_val = '0;
`endif

    always_comb begin
        state_d     = state_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        msb_d       = msb_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        miso_d      = miso_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        underrun_d  = 1'b0;
        upend_d     = upend_q;
        do_load     = 1'b0;
        load_val    = '0;

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (armed_q && !cs_s) begin
                    state_d = LOAD;
                    cpol_d  = cfg_cpol;
                    cpha_d  = cfg_cpha;
                    msb_d   = cfg_msb_first;
                end
            end
            LOAD: begin
                state_d = XFER;
                do_load = 1'b1;
            end
            XFER: begin
                // Underrun is reported once the starved char actually begins clocking.
                if (lead_edge && upend_q) begin
                    underrun_d = 1'b1;
                    upend_d    = 1'b0;
                end
                if (sample_edge) begin
                    rx_sh_d = rx_word;
                    if (last_sample) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        do_load    = !cs_s;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                if (shift_edge) begin
                    miso_d  = msb_q ? tx_sh_q[CHAR_LENGTH-1] : tx_sh_q[0];
                    tx_sh_d = msb_q ? {tx_sh_q[CHAR_LENGTH-2:0], 1'b0}
                                    : {1'b0, tx_sh_q[CHAR_LENGTH-1:1]};
                end
                if (cs_s) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    rx_sh_d   = '0;
                    tx_sh_d   = '0;
                    miso_d    = 1'b0;
                    upend_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            if (hold_full_q) begin
                load_val    = hold_q;
                hold_full_d = 1'b0;
            end else begin
                load_val = fill_val;
                upend_d  = 1'b1;
            end
            tx_sh_d = load_val;
            // CPHA=0: first bit must be on the wire before the first leading edge.
            if ((state_q == LOAD) && !cpha_q) begin
                miso_d  = msb_q ? load_val[CHAR_LENGTH-1] : load_val[0];
                tx_sh_d = msb_q ? {load_val[CHAR_LENGTH-2:0], 1'b0}
                                : {1'b0, load_val[CHAR_LENGTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            msb_q       <= 1'b1;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            miso_q      <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            upend_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpol_q      <= cpol_d;
            cpha_q      <= cpha_d;
            msb_q       <= msb_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            miso_q      <= miso_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            underrun_q  <= underrun_d;
            upend_q     <= upend_d;
        end
    end

    assign miso_oe     = ~cs_s;
    assign miso_o      = miso_q & ~cs_s;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: bit-banged SPI master, rx scoreboard queue popped by a monitor.
module tb_spi_slave_responder;
    localparam int CLK  = 10;
    localparam int HALF = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_msb_first = 1'b1;
    logic       sclk_i = 1'b0, cs_n_i = 1'b1, mosi_i = 1'b0;
    logic       miso_o, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] rx_data;

    logic       m_cpol = 1'b0, m_cpha = 1'b0, m_msb = 1'b1;
    logic [7:0] exp_rx[$];
    int         total = 0;
    int         bad = 0;
    int         underrun_cnt = 0;
    int         u0;

    spi_slave_responder #(.CHAR_LENGTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_msb_first(cfg_msb_first),
        .sclk_i(sclk_i), .cs_n_i(cs_n_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .busy(busy)
    );

    always #(CLK/2) clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every rx_valid pulse must match the oldest expected char.
    always @(negedge clk) begin
        if (rst_n && rx_valid) begin
            if (exp_rx.size() == 0) check("rx_unexpected", {24'h0, rx_data}, 32'hFFFF_FFFF);
            else check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
        end
        if (rst_n && tx_underrun) underrun_cnt++;
    end

    task automatic tx_push(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!tx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("tx_ready_wait", {31'h0, tx_ready}, 32'h1);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("tx_ready_drop", {31'h0, tx_ready}, 32'h0);
    endtask

    task automatic cs_begin(input logic cpol, input logic cpha, input logic msb);
        @(posedge clk); #2;
        cfg_cpol = cpol; cfg_cpha = cpha; cfg_msb_first = msb;
        m_cpol = cpol; m_cpha = cpha; m_msb = msb;
        sclk_i = cpol;
        #(6*CLK);
        cs_n_i = 1'b0;
        #(8*CLK);
    endtask

    task automatic cs_end();
        #HALF;
        cs_n_i = 1'b1;
        #(8*CLK);
    endtask

    task automatic spi_bit(input logic mo, output logic mi);
        if (!m_cpha) begin
            mosi_i = mo; #HALF;
            sclk_i = ~m_cpol; mi = miso_o; #HALF;
            sclk_i = m_cpol;
        end else begin
            sclk_i = ~m_cpol; mosi_i = mo; #HALF;
            sclk_i = m_cpol; mi = miso_o; #HALF;
        end
    endtask

    // exp_miso is the MISO bit stream in time order, first bit in bit 7.
    task automatic spi_byte(input logic [7:0] mo, input logic [7:0] exp_miso, input string nm);
        logic [7:0] got;
        logic       b;
        got = 8'h00;
        exp_rx.push_back(mo);
        for (int i = 0; i < 8; i++) begin
            spi_bit(m_msb ? mo[7-i] : mo[i], b);
            got = {got[6:0], b};
        end
        check(nm, {24'h0, got}, {24'h0, exp_miso});
    endtask

    task automatic drain_check(input string nm);
        check(nm, exp_rx.size(), 0);
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic b;
        logic [7:0] t3a, t3b;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_miso",     {31'h0, miso_o},      32'h0);
        check("rst_miso_oe",  {31'h0, miso_oe},     32'h0);
        check("rst_rx_data",  {24'h0, rx_data},     32'h0);
        check("rst_rx_valid", {31'h0, rx_valid},    32'h0);
        check("rst_tx_ready", {31'h0, tx_ready},    32'h1);
        check("rst_underrun", {31'h0, tx_underrun}, 32'h0);
        check("rst_busy",     {31'h0, busy},        32'h0);

        // 1: mode0 MSB-first, tx 0x3C, master 0xA5
        tx_push(8'h3C);
        u0 = underrun_cnt;
        cs_begin(1'b0, 1'b0, 1'b1);
        check("t1_miso_oe", {31'h0, miso_oe}, 32'h1);
        spi_byte(8'hA5, 8'b0011_1100, "t1_miso");
        cs_end();
        drain_check("t1_rx_count");
        check("t1_underrun", underrun_cnt - u0, 0);

        // 2: mode3 LSB-first, tx 0x81, master 0x0F
        tx_push(8'h81);
        u0 = underrun_cnt;
        cs_begin(1'b1, 1'b1, 1'b0);
        spi_byte(8'h0F, 8'b1000_0001, "t2_miso");
        cs_end();
        drain_check("t2_rx_count");
        check("t2_underrun", underrun_cnt - u0, 0);

        // 3: no tx data, two chars 0x55 then 0x33 in one frame
`ifdef SPI_SLAVE_ECHO_EN
        t3a = 8'h0F;
        t3b = 8'h55;
`else
        t3a = 8'h00;
        t3b = 8'h00;
`endif
        u0 = underrun_cnt;
        cs_begin(1'b0, 1'b0, 1'b1);
        spi_byte(8'h55, t3a, "t3_miso0");
        spi_byte(8'h33, t3b, "t3_miso1");
        cs_end();
        drain_check("t3_rx_count");
        check("t3_underrun", underrun_cnt - u0, 2);

        // 4: mode1, 0x11 preloaded, 0x22 queued mid-frame; cfg changes mid-frame ignored
        tx_push(8'h11);
        u0 = underrun_cnt;
        cs_begin(1'b0, 1'b1, 1'b1);
        cfg_msb_first = 1'b0; cfg_cpha = 1'b0; cfg_cpol = 1'b1;
        fork
            begin
                spi_byte(8'hDE, 8'h11, "t4_miso0");
                spi_byte(8'hAD, 8'h22, "t4_miso1");
            end
            tx_push(8'h22);
        join
        cs_end();
        drain_check("t4_rx_count");
        check("t4_underrun", underrun_cnt - u0, 0);

        // 5: abort after 3 bits, then full frame 0x5A
        cs_begin(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, b);
        check("t5_busy_mid", {31'h0, busy}, 32'h1);
        cs_n_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t5_busy_abort", {31'h0, busy}, 32'h0);
        #(8*CLK);
        check("t5_rx_held", {24'h0, rx_data}, 32'hAD);
        drain_check("t5_no_rx");
        tx_push(8'h96);
        cs_begin(1'b0, 1'b0, 1'b1);
        spi_byte(8'h5A, 8'b1001_0110, "t5_miso");
        cs_end();
        drain_check("t5_rx_count");
        check("t5_rx_data", {24'h0, rx_data}, 32'h5A);

        // 6: mode2, async reset mid-char, then frame 0xC3
        cs_begin(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) spi_bit(i[0], b);
        check("t6_busy_mid", {31'h0, busy}, 32'h1);
        #20;
        rst_n = 1'b0;
        #1;
        check("t6_miso",     {31'h0, miso_o},      32'h0);
        check("t6_miso_oe",  {31'h0, miso_oe},     32'h0);
        check("t6_rx_data",  {24'h0, rx_data},     32'h0);
        check("t6_rx_valid", {31'h0, rx_valid},    32'h0);
        check("t6_tx_ready", {31'h0, tx_ready},    32'h1);
        check("t6_underrun", {31'h0, tx_underrun}, 32'h0);
        check("t6_busy",     {31'h0, busy},        32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_no_fresh_fall", {31'h0, busy}, 32'h0);
        @(posedge clk); #2;
        cs_n_i = 1'b1;
        #(6*CLK);
        tx_push(8'hE7);
        cs_begin(1'b1, 1'b0, 1'b1);
        spi_byte(8'hC3, 8'b1110_0111, "t6_miso_post");
        cs_end();
        drain_check("t6_rx_count");
        check("t6_rx_post", {24'h0, rx_data}, 32'hC3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
